// File: rtl/stream_arb_pkg.sv
// Shared definitions for the round-robin stream arbiter.
// Provides the requester ceiling, the grant index type and the
// round-robin first-set scan used by the pick logic.
package stream_arb_pkg;

  localparam int NREQ_MAX = 16;
  localparam int GIDW     = $clog2(NREQ_MAX);

  typedef logic [GIDW-1:0] grant_idx_t;

  typedef struct packed {
    logic       found;
    grant_idx_t idx;
  } rr_res_t;

  // First set bit at or above ptr; if none, first set bit from 0 (wrap).
  function automatic rr_res_t rr_first(input logic [NREQ_MAX-1:0] valid,
                                       input grant_idx_t          ptr);
    rr_res_t               res;
    logic [NREQ_MAX-1:0]   masked;
    res.found = 1'b0;
    res.idx   = {GIDW{1'b0}};
    for (int i = 0; i < NREQ_MAX; i++) begin
      masked[i] = valid[i] & (i >= int'(ptr));
    end
    // Descending scan so the lowest eligible index wins.
    for (int i = NREQ_MAX - 1; i >= 0; i--) begin
      if (masked[i]) begin
        res.found = 1'b1;
        res.idx   = grant_idx_t'(i);
      end
    end
    if (!res.found) begin
      for (int i = NREQ_MAX - 1; i >= 0; i--) begin
        if (valid[i]) begin
          res.found = 1'b1;
          res.idx   = grant_idx_t'(i);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin select: masked scan from ptr, then unmasked
// scan from 0 so the search wraps around the requester ring.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [NREQ_MAX-1:0] valid_ext_s;
  grant_idx_t          ptr_ext_s;
  rr_res_t             res_s;

  // Widen the request vector to the package ceiling and run the scan.
  always_comb begin
    valid_ext_s             = {NREQ_MAX{1'b0}};
    valid_ext_s[NREQ-1:0]   = valid;
    ptr_ext_s               = grant_idx_t'(ptr);
    res_s                   = rr_first(valid_ext_s, ptr_ext_s);
  end

  assign found = res_s.found;
  assign idx   = IDW'(res_s.idx);

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output slot
// among NREQ requesters. Optional packet locking (keep the grant until
// i_last) is built when ARB_PKT_LOCK_EN is defined.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ*DWIDTH-1:0] i_data,
  input  logic [NREQ-1:0]        i_valid,
  input  logic [NREQ-1:0]        i_last,
  output logic [NREQ-1:0]        o_ready,
  output logic [DWIDTH-1:0]      o_data,
  output logic                   o_valid,
  output logic [IDW-1:0]         o_grant_id,
  input  logic                   i_ready
);

  logic              en_r;
  logic [IDW-1:0]    rr_ptr_r;
  logic              slot_free_s;
  logic              found_s;
  logic              xfer_s;
  logic [IDW-1:0]    pick_s;
  logic [IDW-1:0]    scan_ptr_s;
  logic [IDW-1:0]    nxt_ptr_s;
  logic [NREQ-1:0]   scan_valid_s;
  logic [NREQ-1:0]   ready_s;
  logic [DWIDTH-1:0] sel_data_s;

`ifdef ARB_PKT_LOCK_EN
  logic              lock_r;
  logic [IDW-1:0]    lock_id_r;
  logic              sel_last_s;

  // While a packet is open only the locked requester is eligible.
  always_comb begin
    if (lock_r) begin
      scan_valid_s = i_valid & (NREQ'(1'b1) << lock_id_r);
      scan_ptr_s   = lock_id_r;
    end else begin
      scan_valid_s = i_valid;
      scan_ptr_s   = rr_ptr_r;
    end
  end

  assign sel_last_s = |(ready_s & i_last);
`else
  logic unused_last_s;

  assign scan_valid_s  = i_valid;
  assign scan_ptr_s    = rr_ptr_r;
  assign unused_last_s = ^i_last;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .valid (scan_valid_s),
    .ptr   (scan_ptr_s),
    .found (found_s),
    .idx   (pick_s)
  );

  assign slot_free_s = ~o_valid | i_ready;

  // One-hot ready to the picked requester and the matching data mux.
  always_comb begin
    ready_s    = {NREQ{1'b0}};
    sel_data_s = {DWIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      ready_s[k] = en_r & slot_free_s & found_s & (pick_s == IDW'(k)) & i_valid[k];
      if (pick_s == IDW'(k)) begin
        sel_data_s = i_data[k*DWIDTH +: DWIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  assign o_ready = ready_s;
  assign xfer_s  = |ready_s;

  // Round-robin pointer moves to the requester after the winner, wrapping.
  always_comb begin
    if (pick_s == IDW'(NREQ - 1)) begin
      nxt_ptr_s = {IDW{1'b0}};
    end else begin
      nxt_ptr_s = pick_s + IDW'(1);
    end
  end

  // Arbitration enable rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
    end
  end

  // Output slot: load on transfer, clear on drain, hold under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid    <= 1'b0;
      o_data     <= {DWIDTH{1'b0}};
      o_grant_id <= {IDW{1'b0}};
    end else if (xfer_s) begin
      o_valid    <= 1'b1;
      o_data     <= sel_data_s;
      o_grant_id <= pick_s;
    end else if (o_valid && i_ready) begin
      o_valid    <= 1'b0;
    end else begin
      o_valid    <= o_valid;
    end
  end

`ifdef ARB_PKT_LOCK_EN
  // Packet mode: lock on a non-last beat, release and advance on the last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r  <= {IDW{1'b0}};
      lock_r    <= 1'b0;
      lock_id_r <= {IDW{1'b0}};
    end else if (xfer_s) begin
      if (sel_last_s) begin
        lock_r   <= 1'b0;
        rr_ptr_r <= nxt_ptr_s;
      end else begin
        lock_r    <= 1'b1;
        lock_id_r <= pick_s;
      end
    end else begin
      lock_r <= lock_r;
    end
  end
`else
  // Beat mode: every transfer advances the round-robin pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_r <= {IDW{1'b0}};
    end else if (xfer_s) begin
      rr_ptr_r <= nxt_ptr_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

endmodule
